// File: rtl/wave_capture_sched.sv
// Triggered capture scheduler: fills the back half of a ping-pong trace buffer
// from the DDS stream and swaps halves only at the LCD frame origin.
module wave_capture_sched #(
   parameter int DEPTH   = 1024,
   parameter int AW      = 10,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic        lcd_pclk,
   input  logic        rst,
   input  logic        sample_en,
   input  logic [7:0]  sample_data,
   input  logic [7:0]  trig_level,
   input  logic        trig_mode,
   input  logic        run,
   input  logic [10:0] pixel_xpos,
   input  logic [9:0]  pixel_ypos,
   output logic [7:0]  disp_wave_data,
   output logic        capture_busy,
   output logic        frame_swap,
   output logic        trig_timeout
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

   state_t        state;
   logic          front_sel;
   logic          buf_valid;
   logic          prev_valid;
   logic          at_origin_d;
   logic [7:0]    prev_sample;
   logic [AW-1:0] wr_addr;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    mem [2][DEPTH];

   logic          at_origin;
   logic          frame_start;
   logic          trig_hit;
   logic          tmo_hit;
   logic          wr_en;
   logic          in_range;
   logic [AW-1:0] wr_ptr;

   assign at_origin   = (pixel_xpos == '0) && (pixel_ypos == '0);
   assign frame_start = at_origin && !at_origin_d;
   assign trig_hit    = sample_en && prev_valid && (prev_sample < trig_level)
                        && (sample_data >= trig_level);
   assign tmo_hit     = !trig_mode && (tmo_cnt == TMO_LAST);
   // The trigger sample itself lands at address 0; a stopped wait writes nothing.
   assign wr_en       = ((state == WAIT_TRIG) && run && trig_hit)
                        || ((state == CAPTURE) && sample_en);
   assign wr_ptr      = (state == CAPTURE) ? wr_addr : '0;
   assign in_range    = {21'd0, pixel_xpos} < 32'(DEPTH);

   always_ff @(posedge lcd_pclk)
      if (wr_en) mem[~front_sel][wr_ptr] <= sample_data;

   always_ff @(posedge lcd_pclk) begin
      if (rst)
         disp_wave_data <= '0;
      else if (!buf_valid || !in_range)
         disp_wave_data <= '0;
      else
         disp_wave_data <= mem[front_sel][pixel_xpos[AW-1:0]];
   end

   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         state        <= IDLE;
         front_sel    <= 1'b0;
         buf_valid    <= 1'b0;
         wr_addr      <= '0;
         prev_valid   <= 1'b0;
         prev_sample  <= '0;
         tmo_cnt      <= '0;
         at_origin_d  <= 1'b0;
         capture_busy <= 1'b0;
         frame_swap   <= 1'b0;
         trig_timeout <= 1'b0;
      end else begin
         frame_swap   <= 1'b0;
         trig_timeout <= 1'b0;
         at_origin_d  <= at_origin;
         case (state)
            IDLE: begin
               if (run) begin
                  state        <= WAIT_TRIG;
                  capture_busy <= 1'b1;
                  prev_valid   <= 1'b0;
                  tmo_cnt      <= '0;
               end
            end
            WAIT_TRIG: begin
               if (sample_en) begin
                  prev_sample <= sample_data;
                  prev_valid  <= 1'b1;
               end
               if (!run) begin
                  state        <= IDLE;
                  capture_busy <= 1'b0;
               end else if (trig_hit) begin
                  wr_addr <= AW'(1);
                  state   <= CAPTURE;
               end else if (tmo_hit) begin
                  wr_addr      <= '0;
                  trig_timeout <= 1'b1;
                  state        <= CAPTURE;
               end else if (!trig_mode) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            CAPTURE: begin
               if (sample_en) begin
                  wr_addr <= wr_addr + 1'b1;
                  if (wr_addr == ADDR_LAST) state <= DONE;
               end
            end
            DONE: begin
               // Frame origins seen in any other state are deliberately ignored.
               if (frame_start) begin
                  front_sel  <= ~front_sel;
                  buf_valid  <= 1'b1;
                  frame_swap <= 1'b1;
                  prev_valid <= 1'b0;
                  tmo_cnt    <= '0;
                  if (run) begin
                     state <= WAIT_TRIG;
                  end else begin
                     state        <= IDLE;
                     capture_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               capture_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wave_capture_sched.sv
// Scoreboard bench for wave_capture_sched: a trace-level model predicts each
// displayed sample and each buffer swap; a negedge monitor checks them.
module tb_wave_capture_sched;

   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int TIMEOUT = 100;

   logic        lcd_pclk    = 1'b0;
   logic        rst         = 1'b1;
   logic        sample_en   = 1'b0;
   logic [7:0]  sample_data = '0;
   logic [7:0]  trig_level  = 8'd128;
   logic        trig_mode   = 1'b1;
   logic        run         = 1'b0;
   logic [10:0] pixel_xpos  = 11'd1;
   logic [9:0]  pixel_ypos  = 10'd5;
   logic [7:0]  disp_wave_data;
   logic        capture_busy;
   logic        frame_swap;
   logic        trig_timeout;

   wave_capture_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .lcd_pclk       (lcd_pclk),
      .rst            (rst),
      .sample_en      (sample_en),
      .sample_data    (sample_data),
      .trig_level     (trig_level),
      .trig_mode      (trig_mode),
      .run            (run),
      .pixel_xpos     (pixel_xpos),
      .pixel_ypos     (pixel_ypos),
      .disp_wave_data (disp_wave_data),
      .capture_busy   (capture_busy),
      .frame_swap     (frame_swap),
      .trig_timeout   (trig_timeout)
   );

   always #5 lcd_pclk = ~lcd_pclk;

   int         checks = 0;
   int         passed = 0;
   int         cyc    = 0;
   logic [7:0] rd_q[$];
   int         swap_q[$];
   logic       rd_req   = 1'b0;
   logic       rd_req_d = 1'b0;

   // Trace-level model: displayed trace, trace being filled, trigger search.
   logic [7:0] m_front[DEPTH];
   logic [7:0] m_trace[DEPTH];
   bit         m_valid = 0;
   bit         m_hp    = 0;
   bit         m_trig  = 0;
   logic [7:0] m_prev  = '0;
   int         m_n     = 0;
   logic [7:0] pat[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   always @(posedge lcd_pclk) begin
      cyc      <= cyc + 1;
      rd_req_d <= rd_req;
   end

   always @(negedge lcd_pclk) begin
      if (rd_req_d) begin
         chk("read_expected", int'(rd_q.size() > 0), 1);
         if (rd_q.size() > 0) chk("disp_wave_data", disp_wave_data, rd_q.pop_front());
      end
      if (frame_swap) begin
         chk("swap_expected", int'(swap_q.size() > 0), 1);
         if (swap_q.size() > 0) chk("frame_swap_cycle", cyc, swap_q.pop_front());
      end
   end

   task automatic drive(input bit en, input logic [7:0] d, input logic [10:0] x,
                        input logic [9:0] y, input bit rd);
      sample_en   = en;
      sample_data = d;
      pixel_xpos  = x;
      pixel_ypos  = y;
      rd_req      = rd;
      if (rd) rd_q.push_back((m_valid && x < DEPTH) ? m_front[x[AW-1:0]] : 8'd0);
      @(posedge lcd_pclk);
      #1;
   endtask

   task automatic m_enter_wait();
      m_hp   = 0;
      m_trig = 0;
      m_n    = 0;
   endtask

   task automatic m_strobe(input logic [7:0] s);
      if (!m_trig) begin
         if (m_hp && m_prev < trig_level && s >= trig_level) begin
            m_trig     = 1;
            m_trace[0] = s;
            m_n        = 1;
         end
         m_prev = s;
         m_hp   = 1;
      end else if (m_n < DEPTH) begin
         m_trace[m_n] = s;
         m_n++;
      end
   endtask

   task automatic feed_trace(input int en_pct, input bit origin_last, input int drop_at);
      int guard = 0;
      while (m_n < DEPTH && guard < 3000) begin
         bit          en;
         bit          last;
         logic [7:0]  s;
         logic [10:0] x;
         en = ($urandom_range(99) < en_pct);
         s  = 8'($urandom);
         if (en && pat.size() > 0) s = pat.pop_front();
         x  = 11'($urandom_range(DEPTH + 3));
         if (drop_at > 0 && m_n == drop_at) run = 1'b0;
         if (en) m_strobe(s);
         last = en && (m_n == DEPTH);
         if (last && origin_last) drive(en, s, 11'd0, 10'd0, 1'b0);
         else drive(en, s, x, 10'd5, 1'($urandom_range(1)));
         guard++;
      end
      chk("trace_filled", m_n, DEPTH);
   endtask

   task automatic scan();
      for (int x = 0; x < DEPTH; x++) drive(1'b0, 8'd0, 11'(x), 10'd5, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b0, 8'd0, 11'($urandom_range(1023, DEPTH)), 10'd5, 1'b1);
   endtask

   task automatic swap_frame();
      swap_q.push_back(cyc + 1);
      drive(1'b0, 8'd0, 11'd0, 10'd0, 1'b0);
      m_front = m_trace;
      m_valid = 1;
      m_enter_wait();
   endtask

   task automatic start_run();
      run = 1'b1;
      drive(1'b0, 8'd0, 11'd3, 10'd5, 1'b0);
      m_enter_wait();
   endtask

   initial begin
      int k;
      int tseen;
      for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 11'd1, 10'd5, 1'b0);
      chk("rst_busy", capture_busy, 0);
      chk("rst_swap", frame_swap, 0);
      chk("rst_timeout", trig_timeout, 0);
      chk("rst_disp", disp_wave_data, 0);
      rst = 1'b0;
      scan();

      // First strobe after entry must not trigger even though prev_sample is 0.
      trig_mode  = 1'b1;
      trig_level = 8'd128;
      start_run();
      pat = '{8'd200, 8'd210, 8'd10, 8'd130};
      feed_trace(100, 0, -1);
      scan();
      swap_frame();
      scan();

      // Ramp: trigger crossing at 128, trace wraps through 0.
      pat.delete();
      for (int r = 0; r < 2; r++)
         for (int v = 0; v < 256; v += 16) pat.push_back(8'(v));
      feed_trace(100, 0, -1);
      scan();
      swap_frame();
      scan();
      pat.delete();

      // Randomized traces, some finishing on the frame-origin cycle.
      for (int t = 0; t < 6; t++) begin
         trig_level = 8'($urandom_range(255, 1));
         feed_trace(int'($urandom_range(100, 30)), 1'($urandom_range(1)), -1);
         scan();
         swap_frame();
         scan();
      end

      // Drop run mid-capture: trace completes and swaps, then IDLE.
      trig_level = 8'($urandom_range(200, 60));
      feed_trace(100, 0, 5);
      scan();
      chk("busy_in_done", capture_busy, 1);
      swap_frame();
      chk("busy_after_stop", capture_busy, 0);

      // Auto mode: constant 50 never crosses 200, timeout forces capture.
      trig_mode  = 1'b0;
      trig_level = 8'd200;
      start_run();
      k = 0;
      while (!trig_timeout && k < 300) begin
         drive(1'b1, 8'd50, 11'd7, 10'd5, 1'b0);
         k++;
      end
      chk("timeout_latency", k, TIMEOUT);
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'd50, 11'd7, 10'd5, 1'b0);
         if (i == 0) chk("timeout_pulse_width", trig_timeout, 0);
      end
      for (int i = 0; i < DEPTH; i++) m_trace[i] = 8'd50;
      run = 1'b0;
      scan();
      swap_frame();
      scan();

      // Normal mode with the same stimulus waits forever.
      trig_mode = 1'b1;
      start_run();
      tseen = 0;
      for (int i = 0; i < 2 * TIMEOUT; i++) begin
         drive(1'b1, 8'd50, 11'd7, 10'd5, 1'b0);
         if (trig_timeout) tseen++;
      end
      chk("normal_no_timeout", tseen, 0);
      chk("normal_busy", capture_busy, 1);
      run = 1'b0;
      drive(1'b0, 8'd0, 11'd7, 10'd5, 1'b0);
      chk("wait_stop_idle", capture_busy, 0);
      scan();

      // Reset in the middle of a capture.
      trig_level = 8'd128;
      start_run();
      drive(1'b1, 8'd10, 11'd7, 10'd5, 1'b0);
      drive(1'b1, 8'd200, 11'd7, 10'd5, 1'b0);
      drive(1'b1, 8'd201, 11'd7, 10'd5, 1'b0);
      drive(1'b1, 8'd202, 11'd7, 10'd5, 1'b0);
      rst = 1'b1;
      drive(1'b0, 8'd0, 11'd7, 10'd5, 1'b0);
      rst = 1'b0;
      m_valid = 0;
      chk("midrst_busy", capture_busy, 0);
      chk("midrst_swap", frame_swap, 0);
      chk("midrst_timeout", trig_timeout, 0);
      chk("midrst_disp", disp_wave_data, 0);
      run = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 11'd7, 10'd5, 1'b0);
      chk("midrst_idle", capture_busy, 0);
      scan();
      start_run();
      feed_trace(80, 0, -1);
      scan();
      swap_frame();
      scan();

      for (int i = 0; i < 4; i++) drive(1'b0, 8'd0, 11'd7, 10'd5, 1'b0);
      chk("reads_drained", rd_q.size(), 0);
      chk("swaps_drained", swap_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
